boot_ctrl: RTL
==============

# boot_ctrl

Synthesizable boot and run controller sitting between an external program loader and the single-cycle RISC-V `top`. It streams program words into instruction memory over a valid/ready interface while holding the core in reset. It then releases the core from a fixed boot PC and runs it for a programmed number of cycles or until the core reports halt. It replaces testbench-only memory preloading and fixed cycle loops with hardware that works in simulation, FPGA and silicon.

## Interface
Parameters:
- `ADDR_W`, 10, instruction-memory word-address width; capacity is 2**ADDR_W words.
- `DATA_W`, 32, instruction word width.
- `RESET_PC`, 32'h0000_0000, PC value driven to the core while it is held in reset.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising-edge.
- `n_rst` in 1: asynchronous active-low reset.
- `ld_start` in 1: single-cycle pulse that begins a load.
- `run_cycles` in 32: run limit; 0 means unlimited. Sampled on an accepted `ld_start`.
- `ld_valid` in 1: loader word valid.
- `ld_data` in DATA_W: loader word.
- `ld_last` in 1: qualifies the final word of the program.
- `ld_ready` out 1: controller accepts a word.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_waddr` out ADDR_W: word write address.
- `imem_wdata` out DATA_W: write data.
- `core_n_rst` out 1: active-low reset to the core.
- `core_pc_init` out 32: constant `RESET_PC`.
- `core_halt` in 1: core halt indication (ebreak/ecall decode).
- `busy` out 1: state is LOAD, RELEASE or RUN.
- `done` out 1: state is DONE.
- `load_err` out 1: sticky load error.
- `cycle_count` out 32: number of core cycles executed in RUN.

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE, ERR. The enum is `boot_state_t`.
- IDLE/DONE/ERR + `ld_start` go to LOAD. This clears the word address, `cycle_count`, `load_err` and the checksum, and latches `run_cycles`. `ld_start` is ignored in LOAD, RELEASE and RUN.
- LOAD: `ld_ready`=1. A handshake (`ld_valid`&&`ld_ready`) captures `ld_data` at the current address, then increments the address.
  - Handshake with `ld_last`=1 goes to RELEASE.
  - Handshake at address 2**ADDR_W-1 with `ld_last`=0 goes to ERR with `load_err`=1 and no further writes.
  - Address wrap never occurs.
- RELEASE: lasts exactly one cycle, which lets the final memory write retire. Then RUN.
- RUN: `core_n_rst`=1 and `cycle_count` increments every cycle. Exit to DONE when either:
  - `core_halt`=1 (the halting cycle is counted), or
  - the latched limit is nonzero and `cycle_count` reaches it.
  - If both are true in the same cycle, go to DONE; the result is identical either way.
- DONE/ERR/IDLE/LOAD/RELEASE: `core_n_rst`=0. `cycle_count` holds its value.
- `n_rst` asserted mid-operation returns to IDLE immediately. A partial memory image is left as-is.

## Timing
- Reset values:
  - state IDLE.
  - `ld_ready`, `imem_we`, `core_n_rst`, `busy`, `done`, `load_err` all 0.
  - `imem_waddr`, `imem_wdata`, `cycle_count` all 0.
- Write port is registered: a handshake in cycle N gives `imem_we`=1 with that address and data in cycle N+1.
- `ld_ready` drops in the cycle after the `ld_last` handshake.
- `core_n_rst` rises at the first RUN cycle, two cycles after the `ld_last` handshake. It falls in the cycle after the exit condition.
- `done` and `busy` are decoded from the registered state.
- With limit L>0 and no halt, RUN lasts exactly L cycles and `cycle_count` ends at L.

## Configuration
- `BOOT_CKSUM_EN` defined:
  - Adds input `cksum_exp` [DATA_W-1:0], latched on `ld_start`.
  - Adds output `cksum_err`.
  - A running XOR of accepted words is compared in RELEASE. A mismatch goes to ERR with `cksum_err`=1 and the core is never released.
- `BOOT_CKSUM_EN` undefined: these ports and this logic are absent, and RELEASE always goes to RUN.

## Structure
- `boot_pkg`: `boot_state_t`, `BOOT_PC_W`=32, `CYCLE_W`=32.
- Sub-module `boot_cycle_ctr`: a CYCLE_W counter with clear, enable and limit compare. It outputs a `hit` signal.
- Everything else lives in `boot_ctrl`: FSM, address counter, registered write port and checksum.

## Test plan
- **Load and limited run:** reset, `ld_start` with `run_cycles`=9, 4 words, last on word 3. Expect:
  - `imem_we` at addresses 0..3 with matching data.
  - `core_n_rst` high for exactly 9 cycles.
  - `done`=1 and `cycle_count`=9.
- **Halt exit:** `run_cycles`=0, assert `core_halt` at the 5th RUN cycle. Expect DONE, `cycle_count`=5, and `core_n_rst` low the next cycle.
- **Backpressure gaps:** `ld_valid` toggled 1,0,0,1,1 with last on the final valid. Expect exactly 3 writes at consecutive addresses 0,1,2 and no write in the idle cycles.
- **Overflow:** `ADDR_W`=2, 5 words with no last. Expect 4 writes, then `load_err`=1 and state ERR; the core stays in reset; a new `ld_start` clears `load_err`.
- **Reset mid-RUN:** `n_rst` low in RUN. Expect all outputs at reset values asynchronously; `ld_start` after release reloads correctly.
- **Checksum (`BOOT_CKSUM_EN`):** words 32'h1, 32'h2 with `cksum_exp`=32'h3 gives RUN. The same words with `cksum_exp`=32'h0 give ERR with `cksum_err`=1.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and widths for the boot/run controller.
// Optional checksum logic is enabled by defining BOOT_CKSUM_EN.
package boot_pkg;

    localparam int BOOT_PC_W = 32;
    localparam int CYCLE_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    // States that accept a new load request.
    function automatic logic can_start(boot_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/boot_cycle_ctr.sv
// Run-cycle counter with synchronous clear, enable and limit compare.
// hit_o flags the cycle whose increment makes the count equal the limit.
module boot_cycle_ctr
    import boot_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [CYCLE_W-1:0] limit_i,
    output logic [CYCLE_W-1:0] count_o,
    output logic               hit_o
);

    logic [CYCLE_W-1:0] count_q;
    logic [CYCLE_W-1:0] count_d;
    logic [CYCLE_W-1:0] count_inc;

    assign count_inc = count_q + CYCLE_W'(1);

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_inc;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero limit means run forever, so it never hits.
    assign hit_o   = en_i && (limit_i != '0) && (count_inc == limit_i);
    assign count_o = count_q;

endmodule

// File: rtl/boot_ctrl.sv
// Boot/run controller: streams a program into imem, then runs the core.
// Define BOOT_CKSUM_EN to add the XOR checksum check before release.
module boot_ctrl
    import boot_pkg::*;
#(
    parameter int                   ADDR_W   = 10,
    parameter int                   DATA_W   = 32,
    parameter logic [BOOT_PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 ld_start,
    input  logic [CYCLE_W-1:0]   run_cycles,
    input  logic                 ld_valid,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_waddr,
    output logic [DATA_W-1:0]    imem_wdata,
    output logic                 core_n_rst,
    output logic [BOOT_PC_W-1:0] core_pc_init,
    input  logic                 core_halt,
`ifdef BOOT_CKSUM_EN
    input  logic [DATA_W-1:0]    cksum_exp,
    output logic                 cksum_err,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 load_err,
    output logic [CYCLE_W-1:0]   cycle_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    boot_state_t        state_q;
    boot_state_t        state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic               we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CYCLE_W-1:0] limit_q;
    logic               load_err_q;
    logic               start_ok;
    logic               hs;
    logic               at_max;
    logic               run_en;
    logic               hit;
    logic               cksum_ok;

    assign start_ok = ld_start && can_start(state_q);
    assign hs       = (state_q == ST_LOAD) && ld_valid;
    assign at_max   = (addr_q == ADDR_MAX);
    assign run_en   = (state_q == ST_RUN);

`ifdef BOOT_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;
    logic [DATA_W-1:0] cksum_exp_q;
    logic              cksum_err_q;

    assign cksum_ok = (cksum_q == cksum_exp_q);

    // Running XOR of accepted words and the sticky mismatch flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cksum_q     <= '0;
            cksum_exp_q <= '0;
            cksum_err_q <= 1'b0;
        end else if (start_ok) begin
            cksum_q     <= '0;
            cksum_exp_q <= cksum_exp;
            cksum_err_q <= 1'b0;
        end else begin
            if (hs) begin
                cksum_q <= cksum_q ^ ld_data;
            end
            if ((state_q == ST_RELEASE) && !cksum_ok) begin
                cksum_err_q <= 1'b1;
            end
        end
    end

    assign cksum_err = cksum_err_q;
`else
    assign cksum_ok = 1'b1;
`endif

    // Next state; the address saturates at the top instead of wrapping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (start_ok) begin
            addr_d = '0;
        end else if (hs && !at_max) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (hs && ld_last) begin
                    state_d = ST_RELEASE;
                end else if (hs && at_max) begin
                    state_d = ST_ERR;
                end
            end
            ST_RELEASE: begin
                state_d = cksum_ok ? ST_RUN : ST_ERR;
            end
            ST_RUN: begin
                if (core_halt || hit) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and load address registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Registered imem write port, run limit and overflow flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            limit_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            we_q <= hs;
            if (hs) begin
                waddr_q <= addr_q;
                wdata_q <= ld_data;
            end
            if (start_ok) begin
                limit_q    <= run_cycles;
                load_err_q <= 1'b0;
            end else if (hs && !ld_last && at_max) begin
                load_err_q <= 1'b1;
            end
        end
    end

    boot_cycle_ctr u_ctr (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (start_ok),
        .en_i    (run_en),
        .limit_i (limit_q),
        .count_o (cycle_count),
        .hit_o   (hit)
    );

    assign ld_ready     = (state_q == ST_LOAD);
    assign core_n_rst   = run_en;
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_RELEASE)
                       || run_en;
    assign done         = (state_q == ST_DONE);
    assign load_err     = load_err_q;
    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign core_pc_init = RESET_PC;

endmodule
